// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/reset controller: FSM states and fault codes.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_ERR    = 2'd1;
  localparam logic [1:0] FC_MAXCYC = 2'd2;
  localparam logic [1:0] FC_IDLE   = 2'd3;

endpackage

// File: rtl/run_ctrl_if.sv
// Signal bundle between the run controller (master) and the core/bench side (slave).
interface run_ctrl_if #(
  parameter int CNT_W = 32
);
  // Level protocol, no handshake: err/halt/commit are per-cycle flags sampled at
  // every rising edge while running; clr is a level request acted on only once
  // the controller has stopped. All controller outputs change only at clock edges.
  logic             err;
  logic             halt;
  logic             commit;
  logic             clr;
  logic             core_rst;
  logic             run;
  logic             done;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  err, halt, commit, clr,
    output core_rst, run, done, fault, fault_code, cycle_cnt, retire_cnt
  );

  modport slave (
    output err, halt, commit, clr,
    input  core_rst, run, done, fault, fault_code, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/run_wdog.sv
// Clearable up-counter; tc flags the cycle in which the next increment reaches LIMIT.
module run_wdog #(
  parameter int W     = 32,
  parameter int LIMIT = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);
endmodule

// File: rtl/run_ctrl.sv
// Run/reset sequencer: stretches reset into core_rst, runs the core, and latches
// halt or fault conditions until a clr restart.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 100000,
  parameter int IDLE_LIMIT  = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  run_ctrl_if.master       bus,
  output state_t           fsm_state,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] idle_cnt
);
  state_t           state, state_nxt;
  logic             in_hold, in_run, restart;
  logic             hold_tc, cyc_tc, idle_tc;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;
  logic [1:0]       code_q, code_nxt;

  assign in_hold   = (state == ST_HOLD);
  assign in_run    = (state == ST_RUN);
  assign restart   = bus.clr && (state == ST_DONE || state == ST_FAULT);
  assign fsm_state = state;

  // hold_cnt sits at zero whenever the controller is not holding
  run_wdog #(.W(CNT_W), .LIMIT(HOLD_CYCLES)) u_hold (
    .clk (clk),
    .clr (rst || !in_hold || hold_tc),
    .en  (in_hold),
    .cnt (hold_cnt),
    .tc  (hold_tc)
  );

  run_wdog #(.W(CNT_W), .LIMIT(MAX_CYCLES)) u_cyc (
    .clk (clk),
    .clr (rst || restart),
    .en  (in_run),
    .cnt (cyc_cnt),
    .tc  (cyc_tc)
  );

  run_wdog #(.W(CNT_W), .LIMIT(IDLE_LIMIT)) u_idle (
    .clk (clk),
    .clr (rst || restart || (in_run && bus.commit)),
    .en  (in_run && !bus.commit),
    .cnt (idle_cnt),
    .tc  (idle_tc)
  );

  always_ff @(posedge clk) begin
    if (rst || restart)            ret_cnt <= '0;
    else if (in_run && bus.commit) ret_cnt <= ret_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:  if (hold_tc) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.err)                     state_nxt = ST_FAULT;
        else if (bus.halt)               state_nxt = ST_DONE;
        else if (cyc_tc)                 state_nxt = ST_FAULT;
        else if (!bus.commit && idle_tc) state_nxt = ST_FAULT;
      end
      ST_DONE:  if (bus.clr) state_nxt = ST_HOLD;
      ST_FAULT: if (bus.clr) state_nxt = ST_HOLD;
      default:  state_nxt = ST_HOLD;
    endcase
  end

  // A fault entered from RUN without err can only be cycle limit or idle
  always_comb begin
    code_nxt = FC_NONE;
    if (state_nxt == ST_FAULT) begin
      if (!in_run)      code_nxt = code_q;
      else if (bus.err) code_nxt = FC_ERR;
      else if (cyc_tc)  code_nxt = FC_MAXCYC;
      else              code_nxt = FC_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.core_rst <= 1'b1;
      bus.run      <= 1'b0;
      bus.done     <= 1'b0;
      bus.fault    <= 1'b0;
      code_q       <= FC_NONE;
    end else begin
      bus.core_rst <= (state_nxt == ST_HOLD);
      bus.run      <= (state_nxt == ST_RUN);
      bus.done     <= (state_nxt == ST_DONE);
      bus.fault    <= (state_nxt == ST_FAULT);
      code_q       <= code_nxt;
    end
  end

  assign bus.fault_code = code_q;
  assign bus.cycle_cnt  = cyc_cnt;
  assign bus.retire_cnt = ret_cnt;
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus a random run against
// a cycle-level behavioural model.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int HOLD  = 4;
  localparam int MAXC  = 50;
  localparam int IDLE  = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  state_t           fsm_state;
  logic [CNT_W-1:0] hold_cnt, idle_cnt;
  int               n_checks = 0;
  int               n_errors = 0;

  run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  run_ctrl #(.HOLD_CYCLES(HOLD), .MAX_CYCLES(MAXC), .IDLE_LIMIT(IDLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .fsm_state (fsm_state),
    .hold_cnt  (hold_cnt),
    .idle_cnt  (idle_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: flags and plain integer counters
  bit m_core_rst, m_run, m_done, m_fault;
  int m_code, m_cyc, m_ret, m_idle, m_hold;

  task automatic model_edge(input bit r, input bit e, input bit h, input bit c, input bit cl);
    if (r || ((m_done || m_fault) && cl)) begin
      m_core_rst = 1; m_run = 0; m_done = 0; m_fault = 0;
      m_code = 0; m_cyc = 0; m_ret = 0; m_idle = 0; m_hold = 0;
    end else if (m_core_rst) begin
      if (m_hold == HOLD - 1) begin m_core_rst = 0; m_run = 1; m_hold = 0; end
      else m_hold++;
    end else if (m_run) begin
      m_cyc++;
      if (c) begin m_ret++; m_idle = 0; end
      else m_idle++;
      if (e)                        begin m_fault = 1; m_code = 1; end
      else if (h)                   m_done = 1;
      else if (m_cyc == MAXC)       begin m_fault = 1; m_code = 2; end
      else if (!c && m_idle == IDLE) begin m_fault = 1; m_code = 3; end
      if (m_done || m_fault) m_run = 0;
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit h, input bit c, input bit cl);
    rst = r; bus.err = e; bus.halt = h; bus.commit = c; bus.clr = cl;
    model_edge(r, e, h, c, cl);
    @(posedge clk);
    #1;
  endtask

  task automatic restart_clr();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (HOLD) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (bus.core_rst !== 1'b1) begin n_errors++; $display("FAIL rst_core_rst: got %b expected 1", bus.core_rst); end
    n_checks++; if (bus.run !== 1'b0) begin n_errors++; $display("FAIL rst_run: got %b expected 0", bus.run); end
    n_checks++; if ({bus.done, bus.fault} !== 2'b00) begin n_errors++; $display("FAIL rst_done_fault: got %b expected 00", {bus.done, bus.fault}); end
    n_checks++; if (bus.fault_code !== FC_NONE) begin n_errors++; $display("FAIL rst_code: got %0d expected 0", bus.fault_code); end
    n_checks++; if (bus.cycle_cnt !== '0 || bus.retire_cnt !== '0) begin n_errors++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.retire_cnt); end
    n_checks++; if (fsm_state !== ST_HOLD || hold_cnt !== '0 || idle_cnt !== '0) begin n_errors++; $display("FAIL rst_debug: got state=%0d hold=%0d idle=%0d expected 0/0/0", fsm_state, hold_cnt, idle_cnt); end
    for (int i = 0; i < HOLD; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++; if (bus.core_rst !== (i < HOLD - 1)) begin n_errors++; $display("FAIL hold_core_rst[%0d]: got %b expected %b", i, bus.core_rst, (i < HOLD - 1)); end
      n_checks++; if (bus.run !== (i == HOLD - 1)) begin n_errors++; $display("FAIL hold_run[%0d]: got %b expected %b", i, bus.run, (i == HOLD - 1)); end
    end
    n_checks++; if (bus.cycle_cnt !== '0 || bus.fault_code !== FC_NONE) begin n_errors++; $display("FAIL run_start: got cyc=%0d code=%0d expected 0/0", bus.cycle_cnt, bus.fault_code); end
  endtask

  task automatic test_halt();
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0, 1'b0, (k == 10), 1'b1, 1'b0);
      if (k < 10) begin
        n_checks++; if (bus.run !== 1'b1) begin n_errors++; $display("FAIL halt_running[%0d]: got %b expected 1", k, bus.run); end
      end
    end
    for (int j = 0; j < 6; j++) begin
      n_checks++; if ({bus.done, bus.run, bus.fault} !== 3'b100) begin n_errors++; $display("FAIL halt_flags[%0d]: got %b expected 100", j, {bus.done, bus.run, bus.fault}); end
      n_checks++; if (bus.cycle_cnt !== 32'd10 || bus.retire_cnt !== 32'd10) begin n_errors++; $display("FAIL halt_counts[%0d]: got %0d/%0d expected 10/10", j, bus.cycle_cnt, bus.retire_cnt); end
      if (j < 5) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_err_halt();
    restart_clr();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if ({bus.fault, bus.done, bus.run} !== 3'b100) begin n_errors++; $display("FAIL errhalt_flags: got %b expected 100", {bus.fault, bus.done, bus.run}); end
    n_checks++; if (bus.fault_code !== FC_ERR || bus.cycle_cnt !== 32'd3) begin n_errors++; $display("FAIL errhalt_code_cyc: got %0d/%0d expected 1/3", bus.fault_code, bus.cycle_cnt); end
  endtask

  task automatic test_idle_limit();
    restart_clr();
    for (int k = 1; k <= IDLE; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == IDLE - 1) begin
        n_checks++; if (bus.run !== 1'b1 || bus.fault !== 1'b0) begin n_errors++; $display("FAIL idle_early: got run=%b fault=%b expected 1/0", bus.run, bus.fault); end
      end
    end
    n_checks++; if (bus.fault !== 1'b1 || bus.fault_code !== FC_IDLE) begin n_errors++; $display("FAIL idle_fault: got %b/%0d expected 1/3", bus.fault, bus.fault_code); end
    n_checks++; if (bus.cycle_cnt !== 32'd8 || bus.retire_cnt !== 32'd0) begin n_errors++; $display("FAIL idle_counts: got %0d/%0d expected 8/0", bus.cycle_cnt, bus.retire_cnt); end
    restart_clr();
    for (int k = 1; k <= MAXC; k++) begin
      tick(1'b0, 1'b0, 1'b0, (k % 4 == 0), 1'b0);
      if (k == MAXC - 1) begin
        n_checks++; if (bus.run !== 1'b1) begin n_errors++; $display("FAIL maxc_early: got run=%b expected 1", bus.run); end
      end
    end
    n_checks++; if (bus.fault !== 1'b1 || bus.fault_code !== FC_MAXCYC) begin n_errors++; $display("FAIL maxc_fault: got %b/%0d expected 1/2", bus.fault, bus.fault_code); end
    n_checks++; if (bus.cycle_cnt !== 32'd50 || bus.retire_cnt !== 32'd12) begin n_errors++; $display("FAIL maxc_counts: got %0d/%0d expected 50/12", bus.cycle_cnt, bus.retire_cnt); end
  endtask

  task automatic test_clr();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({bus.core_rst, bus.fault, bus.run} !== 3'b100 || bus.fault_code !== FC_NONE) begin n_errors++; $display("FAIL clr_flags: got %b code=%0d expected 100 code=0", {bus.core_rst, bus.fault, bus.run}, bus.fault_code); end
    n_checks++; if (bus.cycle_cnt !== '0 || bus.retire_cnt !== '0) begin n_errors++; $display("FAIL clr_counts: got %0d/%0d expected 0/0", bus.cycle_cnt, bus.retire_cnt); end
    for (int i = 0; i < HOLD; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (bus.run !== (i == HOLD - 1)) begin n_errors++; $display("FAIL clr_hold[%0d]: got run=%b expected %b", i, bus.run, (i == HOLD - 1)); end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if ({bus.run, bus.core_rst} !== 2'b10 || bus.cycle_cnt !== 32'd1) begin n_errors++; $display("FAIL clr_in_run: got %b cyc=%0d expected 10 cyc=1", {bus.run, bus.core_rst}, bus.cycle_cnt); end
  endtask

  task automatic test_rst_mid_run();
    repeat (18) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (fsm_state !== ST_HOLD || {bus.core_rst, bus.run} !== 2'b10) begin n_errors++; $display("FAIL midrst_state: got %0d %b expected 0 10", fsm_state, {bus.core_rst, bus.run}); end
    n_checks++; if (bus.cycle_cnt !== '0 || bus.retire_cnt !== '0 || idle_cnt !== '0) begin n_errors++; $display("FAIL midrst_counts: got %0d/%0d/%0d expected 0/0/0", bus.cycle_cnt, bus.retire_cnt, idle_cnt); end
    repeat (HOLD) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bus.done !== 1'b1) begin n_errors++; $display("FAIL rstclr_pre: got done=%b expected 1", bus.done); end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (fsm_state !== ST_HOLD || {bus.core_rst, bus.run, bus.done} !== 3'b100) begin n_errors++; $display("FAIL rstclr_state: got %0d %b expected 0 100", fsm_state, {bus.core_rst, bus.run, bus.done}); end
    n_checks++; if (bus.cycle_cnt !== '0 || bus.retire_cnt !== '0 || hold_cnt !== '0) begin n_errors++; $display("FAIL rstclr_counts: got %0d/%0d/%0d expected 0/0/0", bus.cycle_cnt, bus.retire_cnt, hold_cnt); end
  endtask

  task automatic test_random();
    int pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) pct = $urandom_range(0, 100);
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < pct), ($urandom_range(0, 3) == 0));
      n_checks++; if ({bus.core_rst, bus.run, bus.done, bus.fault} !== {m_core_rst, m_run, m_done, m_fault}) begin
        n_errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, {bus.core_rst, bus.run, bus.done, bus.fault}, {m_core_rst, m_run, m_done, m_fault}); end
      n_checks++; if (bus.fault_code !== 2'(m_code)) begin n_errors++; $display("FAIL rnd_code[%0d]: got %0d expected %0d", i, bus.fault_code, m_code); end
      n_checks++; if (bus.cycle_cnt !== 32'(m_cyc)) begin n_errors++; $display("FAIL rnd_cycle[%0d]: got %0d expected %0d", i, bus.cycle_cnt, m_cyc); end
      n_checks++; if (bus.retire_cnt !== 32'(m_ret)) begin n_errors++; $display("FAIL rnd_retire[%0d]: got %0d expected %0d", i, bus.retire_cnt, m_ret); end
    end
  endtask

  initial begin
    bus.err = 1'b0; bus.halt = 1'b0; bus.commit = 1'b0; bus.clr = 1'b0;
    test_reset();
    test_halt();
    test_err_halt();
    test_idle_limit();
    test_clr();
    test_rst_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Synthesizable run/reset controller that sequences the processor core's reset and run phases from the global clk/rst.
- Stretches reset into a core-local reset.
- Tracks cycles and retired instructions.
- Detects halt, core error, cycle-limit and idle (no-progress) conditions, then freezes in a terminal state until cleared.
- Sits between the clock/reset source and the processor top level; done/fault are the bench's stop conditions.

Parameters:
HOLD_CYCLES, 4, cycles core_rst stays high after rst/clr release (>=1)
MAX_CYCLES, 100000, RUN-cycle limit before cycle-limit fault (< 2^CNT_W)
IDLE_LIMIT, 1024, consecutive RUN cycles without commit before idle fault (>=1)
CNT_W, 32, width of cycle/retire counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
err  in  1  core error flag, sampled in RUN only
halt  in  1  core retired HALT this cycle, sampled in RUN only
commit  in  1  one instruction retired this cycle
clr  in  1  restart request, honoured in DONE/FAULT only
core_rst  out  1  reset to core, registered
run  out  1  core running, registered
done  out  1  normal halt reached, sticky
fault  out  1  abnormal stop, sticky
fault_code  out  2  0 none, 1 err, 2 cycle limit, 3 idle timeout
cycle_cnt  out  CNT_W  RUN cycles elapsed
retire_cnt  out  CNT_W  commits counted in RUN

Behaviour:
Interface:
- One clock: clk. Reset port is rst: synchronous, active-high.
- All outputs are registered.

Reset (rst=1 at an edge), from any state including mid-RUN:
- state=HOLD, hold_cnt=0, idle_cnt=0.
- core_rst=1, run=0, done=0, fault=0, fault_code=0, cycle_cnt=0, retire_cnt=0.

HOLD:
- core_rst=1, run=0. hold_cnt increments each edge.
- At the edge where hold_cnt==HOLD_CYCLES-1: go to RUN, core_rst=0, run=1.
- core_rst is therefore high for exactly HOLD_CYCLES cycles after rst deasserts.
- err/halt/commit/clr are ignored.

RUN:
- Each edge: cycle_cnt+1.
- commit=1: retire_cnt+1 and idle_cnt=0; otherwise idle_cnt+1.
- Exit checks at each edge, priority err > halt > cycle limit > idle:
  - err=1 -> FAULT, code 1.
  - halt=1 -> DONE.
  - cycle_cnt+1==MAX_CYCLES -> FAULT, code 2.
  - no commit and idle_cnt+1==IDLE_LIMIT -> FAULT, code 3.
- On the exit edge, counters still update (the final cycle's commit is counted) and run drops.
- clr is ignored.

DONE:
- done=1, run=0, core_rst=0. All counters frozen.
- clr=1 -> HOLD: clears counters, done and hold_cnt; core_rst=1 next cycle.

FAULT:
- fault=1, fault_code held, counters frozen.
- clr=1 -> HOLD: clears fault, fault_code and counters.

Boundaries:
- rst and clr together: rst wins (identical effect).
- err+halt same cycle: FAULT code 1, done stays 0.
- halt on the MAX_CYCLES-th cycle: DONE.
- Counters never wrap: cycle_cnt <= MAX_CYCLES, retire_cnt <= cycle_cnt.
- done and fault are never both 1.

Decomposition:
- Package run_ctrl_pkg: 2-bit state encoding (HOLD, RUN, DONE, FAULT) and fault_code constants (FC_NONE, FC_ERR, FC_MAXCYC, FC_IDLE).
- One sub-module, run_wdog: a clearable up-counter with terminal-count compare, instantiated for hold, cycle and idle counting.
- FSM and output registers stay in run_ctrl.

Test Plan:
Bench parameters: HOLD_CYCLES=4, MAX_CYCLES=50, IDLE_LIMIT=8.
1. rst high 2 cycles, then low -> core_rst=1 for exactly 4 cycles; run=1 after the 4th edge; cycle_cnt=0, fault_code=0.
2. commit=1 every RUN cycle, halt=1 with commit on the 10th RUN cycle -> next cycle done=1, run=0, cycle_cnt=10, retire_cnt=10, fault=0; held 5 further cycles unchanged.
3. err=1 and halt=1 together on the 3rd RUN cycle -> fault=1, fault_code=1, done=0, cycle_cnt=3.
4. commit held 0 from RUN start -> fault=1, fault_code=3 after the 8th RUN cycle, cycle_cnt=8, retire_cnt=0; then commit once every 4 cycles -> fault=1, fault_code=2 at cycle_cnt=50, retire_cnt=12.
5. In FAULT, clr=1 for 1 cycle -> next cycle core_rst=1, fault=0, fault_code=0, counters 0; run=1 again after 4 hold cycles. clr pulsed during RUN -> no effect.
6. rst=1 on the 20th RUN cycle -> next cycle state HOLD, core_rst=1, run=0, all counters 0; rst together with clr in DONE -> same result.
